// File: rtl/nunchuk_stream_decoder.sv
// Nunchuk report stream decoder: collects six bytes over valid/ready,
// optionally decrypts, and publishes a registered decoded frame.
module nunchuk_stream_decoder #(
  parameter int ACCEL_W  = 10,
  parameter int DEADZONE = 8,
  parameter bit DECRYPT  = 1'b0,
  parameter int TIMEOUT  = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          byte_in,
  input  logic                byte_valid,
  output logic                byte_ready,
  input  logic                frame_start,
  output logic signed [8:0]   stick_x,
  output logic signed [8:0]   stick_y,
  output logic [ACCEL_W-1:0]  accel_x,
  output logic [ACCEL_W-1:0]  accel_y,
  output logic [ACCEL_W-1:0]  accel_z,
  output logic                z,
  output logic                c,
  output logic                frame_valid,
  output logic [15:0]         frame_count,
  output logic                err_timeout
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic {
    COLLECT,
    PUBLISH
  } state_t;

  state_t        state;
  logic [2:0]    idx;
  logic [CW-1:0] tcnt;
  logic [7:0]    slot [6];

  logic          xfer;
  logic [7:0]    din;
  logic [9:0]    raw_x;
  logic [9:0]    raw_y;
  logic [9:0]    raw_z;

  assign xfer  = byte_valid & byte_ready;
  assign din   = DECRYPT ? ((byte_in ^ 8'h17) + 8'h17) : byte_in;
  assign raw_x = {slot[2], slot[5][3:2]};
  assign raw_y = {slot[3], slot[5][5:4]};
  assign raw_z = {slot[4], slot[5][7:6]};

  // Centre around 128, then squash small magnitudes to zero.
  function automatic logic signed [8:0] centre(input logic [7:0] b);
    logic signed [8:0] s;
    logic [8:0]        m;
    s = $signed({1'b0, b}) - 9'sd128;
    m = s[8] ? 9'(-s) : 9'(s);
    if (m <= 9'(DEADZONE)) centre = '0;
    else centre = s;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= COLLECT;
      idx         <= '0;
      tcnt        <= '0;
      byte_ready  <= 1'b0;
      stick_x     <= '0;
      stick_y     <= '0;
      accel_x     <= '0;
      accel_y     <= '0;
      accel_z     <= '0;
      z           <= 1'b0;
      c           <= 1'b0;
      frame_valid <= 1'b0;
      frame_count <= '0;
      err_timeout <= 1'b0;
      for (int i = 0; i < 6; i++) slot[i] <= '0;
    end else begin
      frame_valid <= 1'b0;
      err_timeout <= 1'b0;
      unique case (state)
        COLLECT: begin
          byte_ready <= 1'b1;
          if (xfer) begin
            tcnt <= '0;
            if (frame_start) begin
              slot[0] <= din;
              idx     <= 3'd1;
            end else begin
              for (int i = 0; i < 6; i++)
                if (idx == 3'(i)) slot[i] <= din;
              if (idx == 3'd5) begin
                idx        <= '0;
                state      <= PUBLISH;
                byte_ready <= 1'b0;
              end else begin
                idx <= idx + 3'd1;
              end
            end
          end else if (frame_start) begin
            idx  <= '0;
            tcnt <= '0;
          end else if (idx != 3'd0) begin
            // Reaching the limit on this edge drops the partial frame.
            if (tcnt == CW'(TIMEOUT - 1)) begin
              idx         <= '0;
              tcnt        <= '0;
              err_timeout <= 1'b1;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        PUBLISH: begin
          stick_x     <= centre(slot[0]);
          stick_y     <= centre(slot[1]);
          accel_x     <= raw_x[9 -: ACCEL_W];
          accel_y     <= raw_y[9 -: ACCEL_W];
          accel_z     <= raw_z[9 -: ACCEL_W];
          z           <= ~slot[5][0];
          c           <= ~slot[5][1];
          frame_valid <= 1'b1;
          frame_count <= frame_count + 16'd1;
          state       <= COLLECT;
          byte_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nunchuk_stream_decoder.sv
// Bench for nunchuk_stream_decoder: three parameterisations share one
// stimulus stream and are compared against a queue-based frame model.
module tb_nunchuk_stream_decoder;

  localparam int TO = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] byte_in = '0;
  logic byte_valid = 1'b0;
  logic frame_start = 1'b0;

  logic rdy [3];
  logic signed [8:0] sx [3];
  logic signed [8:0] sy [3];
  logic [9:0] ax [2];
  logic [9:0] ay [2];
  logic [9:0] az [2];
  logic [7:0] ax8, ay8, az8;
  logic zb [3];
  logic cb [3];
  logic fv [3];
  logic er [3];
  logic [15:0] fc [3];

  always #5 clk = ~clk;

  nunchuk_stream_decoder #(.ACCEL_W(10), .DEADZONE(8), .DECRYPT(1'b0), .TIMEOUT(TO)) u_a (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(rdy[0]), .frame_start(frame_start), .stick_x(sx[0]), .stick_y(sy[0]),
    .accel_x(ax[0]), .accel_y(ay[0]), .accel_z(az[0]), .z(zb[0]), .c(cb[0]),
    .frame_valid(fv[0]), .frame_count(fc[0]), .err_timeout(er[0]));

  nunchuk_stream_decoder #(.ACCEL_W(10), .DEADZONE(8), .DECRYPT(1'b1), .TIMEOUT(TO)) u_b (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(rdy[1]), .frame_start(frame_start), .stick_x(sx[1]), .stick_y(sy[1]),
    .accel_x(ax[1]), .accel_y(ay[1]), .accel_z(az[1]), .z(zb[1]), .c(cb[1]),
    .frame_valid(fv[1]), .frame_count(fc[1]), .err_timeout(er[1]));

  nunchuk_stream_decoder #(.ACCEL_W(8), .DEADZONE(8), .DECRYPT(1'b0), .TIMEOUT(TO)) u_c (
    .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(rdy[2]), .frame_start(frame_start), .stick_x(sx[2]), .stick_y(sy[2]),
    .accel_x(ax8), .accel_y(ay8), .accel_z(az8), .z(zb[2]), .c(cb[2]),
    .frame_valid(fv[2]), .frame_count(fc[2]), .err_timeout(er[2]));

  int nvec = 0;
  int nfail = 0;

  // Reference model: accepted bytes of the current frame, idle run length.
  int q[$];
  int idle_run;
  bit pub;
  bit mr;
  int frame [6];
  int cnt;
  bit efv, eerr;
  logic [8:0] esx [3];
  logic [8:0] esy [3];
  int eax [3];
  int eay [3];
  int eaz [3];
  bit ez [3];
  bit ec [3];

  function automatic int dcr(int b, bit d);
    if (d) return ((b ^ 'h17) + 'h17) % 256;
    return b;
  endfunction

  function automatic logic [8:0] mstick(int b);
    int s;
    int m;
    s = b - 128;
    m = (s < 0) ? -s : s;
    if (m <= 8) return 9'd0;
    return 9'(s);
  endfunction

  task automatic publish();
    int g [6];
    int w;
    for (int i = 0; i < 3; i++) begin
      w = (i == 2) ? 8 : 10;
      for (int k = 0; k < 6; k++) g[k] = dcr(frame[k], i == 1);
      esx[i] = mstick(g[0]);
      esy[i] = mstick(g[1]);
      eax[i] = (g[2] * 4 + ((g[5] / 4) % 4)) / (1 << (10 - w));
      eay[i] = (g[3] * 4 + ((g[5] / 16) % 4)) / (1 << (10 - w));
      eaz[i] = (g[4] * 4 + ((g[5] / 64) % 4)) / (1 << (10 - w));
      ez[i] = (g[5] % 2) == 0;
      ec[i] = ((g[5] / 2) % 2) == 0;
    end
    cnt = (cnt + 1) % 65536;
    efv = 1'b1;
  endtask

  task automatic model_reset();
    q.delete();
    idle_run = 0;
    pub = 1'b0;
    mr = 1'b0;
    cnt = 0;
    efv = 1'b0;
    eerr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      esx[i] = '0; esy[i] = '0;
      eax[i] = 0; eay[i] = 0; eaz[i] = 0;
      ez[i] = 1'b0; ec[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit v, input logic [7:0] d, input bit fs);
    efv = 1'b0;
    eerr = 1'b0;
    if (pub) begin
      publish();
      pub = 1'b0;
      mr = 1'b1;
    end else begin
      if (v && mr) begin
        idle_run = 0;
        if (fs) q.delete();
        q.push_back(int'(d));
        if (q.size() == 6) begin
          for (int k = 0; k < 6; k++) frame[k] = q[k];
          q.delete();
          pub = 1'b1;
        end
      end else if (fs) begin
        q.delete();
        idle_run = 0;
      end else if (q.size() > 0) begin
        idle_run++;
        if (idle_run == TO) begin
          q.delete();
          idle_run = 0;
          eerr = 1'b1;
        end
      end
      mr = !pub;
    end
  endtask

  task automatic chk(input string tag, input int i, input logic [31:0] o, input logic [31:0] e);
    nvec++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s[%0d] observed %h expected %h", tag, i, o, e);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk("ready", i, 32'(rdy[i]), 32'(mr));
      chk("frame_valid", i, 32'(fv[i]), 32'(efv));
      chk("err_timeout", i, 32'(er[i]), 32'(eerr));
      chk("frame_count", i, 32'(fc[i]), 32'(cnt));
      chk("stick_x", i, 32'($unsigned(sx[i])), 32'(esx[i]));
      chk("stick_y", i, 32'($unsigned(sy[i])), 32'(esy[i]));
      chk("z", i, 32'(zb[i]), 32'(ez[i]));
      chk("c", i, 32'(cb[i]), 32'(ec[i]));
    end
    for (int i = 0; i < 2; i++) begin
      chk("accel_x", i, 32'(ax[i]), 32'(eax[i]));
      chk("accel_y", i, 32'(ay[i]), 32'(eay[i]));
      chk("accel_z", i, 32'(az[i]), 32'(eaz[i]));
    end
    chk("accel_x", 2, 32'(ax8), 32'(eax[2]));
    chk("accel_y", 2, 32'(ay8), 32'(eay[2]));
    chk("accel_z", 2, 32'(az8), 32'(eaz[2]));
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit fs, output bit acc);
    @(negedge clk);
    byte_valid = v;
    byte_in = d;
    frame_start = fs;
    @(posedge clk);
    acc = v && mr;
    model_edge(v, d, fs);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) step(1'b0, 8'h00, 1'b0, acc);
  endtask

  task automatic send(input logic [7:0] d, input bit fs);
    bit acc;
    int k;
    k = 0;
    step(1'b1, d, fs, acc);
    while (!acc && k < 10) begin
      step(1'b1, d, 1'b0, acc);
      k++;
    end
    if (!acc) begin
      nvec++;
      nfail++;
      $error("FAIL send_stall observed no transfer expected transfer within 10 cycles");
    end
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    send(b0, 1'b0); send(b1, 1'b0); send(b2, 1'b0);
    send(b3, 1'b0); send(b4, 1'b0); send(b5, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    byte_valid = 1'b0;
    frame_start = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    model_edge(1'b0, 8'h00, 1'b0);
    #1;
    check_all();
  endtask

  initial begin
    int g;
    int r;
    do_reset();

    // Defaults: centred sticks, full-width accel, released buttons.
    send_frame(8'h80, 8'h80, 8'h12, 8'h34, 8'h56, 8'hE7);
    idle(1);
    chk("t1_fv", 0, 32'(fv[0]), 32'd1);
    chk("t1_ax", 0, 32'(ax[0]), 32'h049);
    chk("t1_ay", 0, 32'(ay[0]), 32'h0D2);
    chk("t1_az", 0, 32'(az[0]), 32'h15B);
    chk("t1_sx", 0, 32'($unsigned(sx[0])), 32'h000);
    chk("t1_zc", 0, {30'd0, zb[0], cb[0]}, 32'd0);
    chk("t1_count", 0, 32'(fc[0]), 32'd1);
    idle(2);

    // Stick extremes and pressed buttons.
    send_frame(8'hFF, 8'h00, 8'h12, 8'h34, 8'h56, 8'hFC);
    idle(1);
    chk("t2_sx", 0, 32'($unsigned(sx[0])), 32'h07F);
    chk("t2_sy", 0, 32'($unsigned(sy[0])), 32'h180);
    chk("t2_zc", 0, {30'd0, zb[0], cb[0]}, 32'd3);
    chk("t2_ax8", 2, 32'(ax8), 32'h12);

    // Deadzone edge: 6 is inside, 9 is outside.
    send_frame(8'h86, 8'h89, 8'h12, 8'h34, 8'h56, 8'hFC);
    idle(1);
    chk("t3_sx", 0, 32'($unsigned(sx[0])), 32'h000);
    chk("t3_sy", 0, 32'($unsigned(sy[0])), 32'h009);

    // Legacy decryption.
    send_frame(8'h7E, 8'h7E, 8'h00, 8'h00, 8'h00, 8'hE8);
    idle(1);
    chk("t4_sx", 1, 32'($unsigned(sx[1])), 32'h000);
    chk("t4_zc", 1, {30'd0, zb[1], cb[1]}, 32'd2);

    // Timeout after 20 idle cycles, then a clean frame.
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
    idle(19);
    chk("t5_noerr", 0, 32'(er[0]), 32'd0);
    idle(1);
    chk("t5_err", 0, 32'(er[0]), 32'd1);
    idle(1);
    chk("t5_pulse", 0, 32'(er[0]), 32'd0);
    send_frame(8'hA0, 8'h40, 8'h01, 8'h02, 8'h03, 8'h55);
    idle(1);
    chk("t5_count", 0, 32'(fc[0]), 32'd5);

    // Byte on the 20th idle cycle wins over the timeout.
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
    idle(19);
    send(8'h44, 1'b0);
    chk("t6_noerr", 0, 32'(er[0]), 32'd0);
    send(8'h55, 1'b0); send(8'h0F, 1'b0);
    idle(1);
    chk("t6_count", 0, 32'(fc[0]), 32'd6);

    // Resync coincident with a byte.
    send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b0); send(8'hDD, 1'b0);
    send(8'h80, 1'b1);
    send(8'h90, 1'b0); send(8'h12, 1'b0); send(8'h34, 1'b0); send(8'h56, 1'b0); send(8'hFC, 1'b0);
    idle(1);
    chk("t7_count", 0, 32'(fc[0]), 32'd7);
    chk("t7_sy", 0, 32'($unsigned(sy[0])), 32'h010);

    // Valid held high across PUBLISH.
    send_frame(8'h01, 8'hF0, 8'h9A, 8'hBC, 8'hDE, 8'h3C);
    send_frame(8'hC0, 8'h30, 8'h65, 8'h43, 8'h21, 8'hC3);
    idle(1);
    chk("t8_count", 0, 32'(fc[0]), 32'd9);

    // Randomised traffic with gaps near the timeout and occasional resync.
    for (int f = 0; f < 150; f++) begin
      for (int k = 0; k < 6; k++) begin
        r = $urandom_range(0, 99);
        g = (r < 6) ? $urandom_range(17, 22) : (r < 30) ? $urandom_range(1, 3) : 0;
        idle(g);
        send(8'($urandom_range(0, 255)), $urandom_range(0, 49) == 0);
      end
    end
    idle(3);

    // Reset mid-frame.
    send(8'h12, 1'b0); send(8'h34, 1'b0); send(8'h56, 1'b0);
    do_reset();
    chk("t9_zero_count", 0, 32'(fc[0]), 32'd0);
    send_frame(8'h80, 8'h80, 8'h12, 8'h34, 8'h56, 8'hE7);
    idle(1);
    chk("t9_count", 0, 32'(fc[0]), 32'd1);
    chk("t9_ax", 0, 32'(ax[0]), 32'h049);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
